// File: rtl/perf_counter_snapshot_packer.sv
// Snapshots a bank of event counters on a trigger and streams them out as an AXI4-Stream frame.
// Optional PERF_PACKER_TIMESTAMP_EN prepends a 32-bit cycle-count header beat to each frame.
module perf_counter_snapshot_packer #(
  parameter int unsigned NUM_COUNTERS  = 115,
  parameter int unsigned COUNTER_WIDTH = 7,
  parameter int unsigned TDATA_WIDTH   = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
  input  logic                                  sample_trigger,
  output logic                                  counters_clear,
  output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic [15:0]                           dropped_triggers
);

  localparam int unsigned FLAT_W = NUM_COUNTERS * COUNTER_WIDTH;
  localparam int unsigned CPB    = TDATA_WIDTH / COUNTER_WIDTH;
  localparam int unsigned NBEATS = (NUM_COUNTERS + CPB - 1) / CPB;
`ifdef PERF_PACKER_TIMESTAMP_EN
  localparam int unsigned HDR_BEATS = 1;
`else
  localparam int unsigned HDR_BEATS = 0;
`endif
  localparam int unsigned NFRAME = NBEATS + HDR_BEATS;
  localparam int unsigned BEAT_W = (NFRAME > 1) ? $clog2(NFRAME) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NFRAME - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d, next_beat;
  logic [FLAT_W-1:0]        snapshot_q, snapshot_d, src_flat;
  logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d, next_tdata;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic                     clear_q, clear_d;
  logic [15:0]              dropped_q, dropped_d;
  logic                     hs, last_hs, load;
`ifdef PERF_PACKER_TIMESTAMP_EN
  logic [31:0]              cyc_q, ts_q, ts_d, src_ts;
`endif

  // Gathers the counters belonging to one data beat; slots past the last counter stay zero.
  function automatic logic [TDATA_WIDTH-1:0] pack_beat(input logic [FLAT_W-1:0] flat,
                                                      input int unsigned      data_idx);
    logic [TDATA_WIDTH-1:0] beat;
    int unsigned            c;
    beat = '0;
    for (int unsigned j = 0; j < CPB; j++) begin
      c = data_idx * CPB + j;
      if (c < NUM_COUNTERS) begin
        beat[j*COUNTER_WIDTH +: COUNTER_WIDTH] = flat[c*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
    return beat;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    snapshot_d = snapshot_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    clear_d    = 1'b0;
    dropped_d  = dropped_q;
`ifdef PERF_PACKER_TIMESTAMP_EN
    ts_d       = ts_q;
`endif

    hs      = tvalid_q && m_axis_tready;
    last_hs = hs && tlast_q;
    // A trigger is taken when idle or exactly on the closing handshake of a frame.
    load    = sample_trigger && ((state_q == IDLE) || last_hs);

    src_flat  = load ? counters_flat : snapshot_q;
    next_beat = load ? '0 : beat_q + BEAT_W'(1);
`ifdef PERF_PACKER_TIMESTAMP_EN
    src_ts     = load ? cyc_q : ts_q;
    next_tdata = (next_beat == '0) ? TDATA_WIDTH'(src_ts)
                                   : pack_beat(src_flat, 32'(next_beat) - 32'd1);
`else
    next_tdata = pack_beat(src_flat, 32'(next_beat));
`endif

    if (load) begin
      state_d    = SEND;
      beat_d     = next_beat;
      snapshot_d = counters_flat;
`ifdef PERF_PACKER_TIMESTAMP_EN
      ts_d       = cyc_q;
`endif
      tdata_d    = next_tdata;
      tvalid_d   = 1'b1;
      tlast_d    = (next_beat == LAST_BEAT);
      clear_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        SEND: begin
          if (sample_trigger && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
          end
          if (last_hs) begin
            state_d  = IDLE;
            beat_d   = '0;
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else if (hs) begin
            beat_d  = next_beat;
            tdata_d = next_tdata;
            tlast_d = (next_beat == LAST_BEAT);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      snapshot_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      clear_q    <= 1'b0;
      dropped_q  <= '0;
`ifdef PERF_PACKER_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      snapshot_q <= snapshot_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      clear_q    <= clear_d;
      dropped_q  <= dropped_d;
`ifdef PERF_PACKER_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

`ifdef PERF_PACKER_TIMESTAMP_EN
  // Free-running cycle counter sampled into the header beat
  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_q + 32'd1;
  end
`endif

  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign counters_clear   = clear_q;
  assign dropped_triggers = dropped_q;
  assign busy             = (state_q == SEND);

endmodule

// File: tb/tb_perf_counter_snapshot_packer.sv
// Scoreboard bench for perf_counter_snapshot_packer at default parameters (CPB=9, 13 data beats).
`timescale 1ns/1ps
module tb_perf_counter_snapshot_packer;
  localparam int NC = 115, CW = 7, TW = 64, CPB = 9, NBEATS = 13;
`ifdef PERF_PACKER_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NFRAME = NBEATS + HDR;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CW-1:0]     cnt [NC];
  logic [NC*CW-1:0]  counters_flat;
  logic              sample_trigger;
  logic              counters_clear;
  logic [TW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic [15:0]       dropped_triggers;

  perf_counter_snapshot_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .counters_flat    (counters_flat),
    .sample_trigger   (sample_trigger),
    .counters_clear   (counters_clear),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .busy             (busy),
    .dropped_triggers (dropped_triggers)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NC; i++) counters_flat[i*CW +: CW] = cnt[i];
  end

  // Reference cycle count: value the DUT should stamp for a trigger driven now
  logic [31:0] tb_cyc = '0;
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  beat_t sb[$];
  int    tests = 0, fails = 0;
  int    hs_cnt = 0, last_cnt = 0, clear_cnt = 0;
  int    h0, l0, c0, cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected frame built from the current bench counter values
  task automatic push_frame(input logic [31:0] ts);
    beat_t b;
    if (HDR == 1) begin
      b.data = 64'(ts);
      b.last = 1'b0;
      sb.push_back(b);
    end
    for (int k = 0; k < NBEATS; k++) begin
      b.data = '0;
      for (int j = 0; j < CPB; j++) begin
        if (k * CPB + j < NC) b.data[j*CW +: CW] = cnt[k*CPB + j];
      end
      b.last = (k == NBEATS - 1);
      sb.push_back(b);
    end
  endtask

  task automatic wait_idle();
    for (cyc = 0; cyc < 300 && (m_axis_tvalid || sb.size() != 0); cyc++) step();
    check("frame_complete", 64'(m_axis_tvalid || sb.size() != 0), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  task automatic monitor();
    beat_t         exp;
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
            fails++;
            $display("FAIL stall_hold: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
          end
        end
        if (counters_clear) clear_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
          hs_cnt++;
          if (m_axis_tlast) last_cnt++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got d=%h l=%0b expected no beat", m_axis_tdata, m_axis_tlast);
          end else begin
            exp = sb.pop_front();
            if (m_axis_tdata !== exp.data || m_axis_tlast !== exp.last) begin
              fails++;
              $display("FAIL beat_data: got d=%h l=%0b expected d=%h l=%0b",
                       m_axis_tdata, m_axis_tlast, exp.data, exp.last);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sample_trigger = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < NC; i++) cnt[i] = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) step();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_clear", 64'(counters_clear), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dropped", 64'(dropped_triggers), 64'd0);
    rst_n = 1'b1;
    step();

    // Single frame, counter i = i mod 128, tready held high
    for (int i = 0; i < NC; i++) cnt[i] = 7'(i % 128);
    m_axis_tready = 1'b1;
    c0 = clear_cnt; h0 = hs_cnt; l0 = last_cnt;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    check("latency1_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("clear_pulse", 64'(counters_clear), 64'd1);
    check("busy_send", 64'(busy), 64'd1);
    check("first_not_last", 64'(m_axis_tlast), 64'd0);
    step();
    check("clear_one_cycle", 64'(counters_clear), 64'd0);
    for (int b = 2; b < NFRAME; b++) begin
      step();
      check("consecutive_valid", 64'(m_axis_tvalid), 64'd1);
    end
    check("final_tlast", 64'(m_axis_tlast), 64'd1);
    check("beat12_first", 64'(m_axis_tdata[6:0]), 64'd108);
    check("beat12_last_counter", 64'(m_axis_tdata[48:42]), 64'd114);
    check("beat12_pad_zero", 64'(m_axis_tdata[63:49]), 64'd0);
    step();
    check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("clear_count", 64'(clear_cnt - c0), 64'd1);
    check("handshakes", 64'(hs_cnt - h0), 64'(NFRAME));
    check("tlast_count", 64'(last_cnt - l0), 64'd1);

    // Backpressure with counters changing after the trigger
    for (int i = 0; i < NC; i++) cnt[i] = 7'($urandom_range(0, 127));
    h0 = hs_cnt;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    for (cyc = 0; cyc < 200 && (m_axis_tvalid || sb.size() != 0); cyc++) begin
      m_axis_tready = ~m_axis_tready;
      for (int i = 0; i < NC; i++) cnt[i] = 7'($urandom_range(0, 127));
      step();
    end
    check("stall_frame_done", 64'(m_axis_tvalid || sb.size() != 0), 64'd0);
    check("stall_handshakes", 64'(hs_cnt - h0), 64'(NFRAME));

    // Three triggers while beats 2..4 are on the bus
    m_axis_tready = 1'b1;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    step();
    step();
    repeat (3) begin
      sample_trigger = 1'b1;
      step();
    end
    sample_trigger = 1'b0;
    wait_idle();
    check("dropped_three", 64'(dropped_triggers), 64'd3);

    // Saturation: trigger held high across a stalled frame
    m_axis_tready = 1'b0;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    repeat (70000) step();
    sample_trigger = 1'b0;
    check("dropped_saturate", 64'(dropped_triggers), 64'hFFFF);
    m_axis_tready = 1'b1;
    wait_idle();

    // Trigger coincident with the final handshake chains frames back to back
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    repeat (NFRAME - 1) step();
    check("chain_at_last", 64'(m_axis_tlast), 64'd1);
    for (int i = 0; i < NC; i++) cnt[i] = 7'(127 - i);
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    check("chain_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("chain_clear", 64'(counters_clear), 64'd1);
    check("chain_first_not_last", 64'(m_axis_tlast), 64'd0);
    repeat (NFRAME - 1) begin
      step();
      check("chain_no_gap", 64'(m_axis_tvalid), 64'd1);
    end
    check("chain_dropped", 64'(dropped_triggers), 64'hFFFF);
    wait_idle();

    // Reset in the middle of a frame
    l0 = last_cnt;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    sample_trigger = 1'b1;
    step();
    rst_n = 1'b1;
    sample_trigger = 1'b0;
    sb.delete();
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_dropped", 64'(dropped_triggers), 64'd0);
    check("midrst_no_tlast", 64'(last_cnt - l0), 64'd0);
    step();
    check("rst_trigger_ignored", 64'(m_axis_tvalid), 64'd0);
    h0 = hs_cnt; l0 = last_cnt;
    push_frame(tb_cyc);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    wait_idle();
    check("post_rst_handshakes", 64'(hs_cnt - h0), 64'(NFRAME));
    check("post_rst_tlast", 64'(last_cnt - l0), 64'd1);

`ifdef PERF_PACKER_TIMESTAMP_EN
    // Timestamp header: trigger sampled when the cycle counter reads 100
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (100) step();
    h0 = hs_cnt; l0 = last_cnt;
    push_frame(32'd100);
    sample_trigger = 1'b1;
    step();
    sample_trigger = 1'b0;
    check("ts_header", m_axis_tdata, 64'd100);
    wait_idle();
    check("ts_handshakes", 64'(hs_cnt - h0), 64'd14);
    check("ts_tlast", 64'(last_cnt - l0), 64'd1);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
